imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
Writer side of the CPU's instruction-fetch path. It receives a program as a byte stream over a valid/ready handshake and packs it into 32-bit words. It writes those words into the instruction memory write port, holding the CPU in reset until the load completes. It then releases the CPU so fetch starts at PC 0.

Parameters:
ADDR_W, 12, instruction-memory word-address width; matches the 12-bit PC, so capacity is 2**ADDR_W words.
TIMEOUT, 50000, maximum cycles allowed between accepted bytes once a load has started.

Ports:
clk  input  1  system clock; all logic on the rising edge
rst_n  input  1  synchronous, active-low reset
start  input  1  single-cycle request to begin or restart a load
rx_data  input  8  incoming program byte
rx_valid  input  1  rx_data is valid
rx_ready  output  1  loader accepts a byte this cycle
imem_we  output  1  instruction-memory write enable, one-cycle pulse
imem_addr  output  ADDR_W  word address of the write
imem_wdata  output  32  instruction word
cpu_rst_n  output  1  active-low reset to the CPU; 0 = CPU held in reset
busy  output  1  load in progress
done  output  1  load complete, CPU running
err  output  1  load aborted (oversize length or timeout)
words_loaded  output  ADDR_W+1  count of words written in the current or last load

Behaviour:
- Reset (rst_n=0 at a clock edge): state IDLE; rx_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_rst_n=0, busy=0, done=0, err=0, words_loaded=0. A reset mid-load abandons the load; words already written stay in memory.
- All outputs are registered.
- A byte is accepted only on a cycle where rx_valid=1 and rx_ready=1. When rx_ready=0, rx_valid is ignored and the byte is not consumed.
- Frame format: 2-byte little-endian word count N, then N words of 4 bytes each, each word little-endian (first byte is bits 7:0).
- FSM states: IDLE, LEN_LO, LEN_HI, WORD, WRITE, RUN, ERROR.
  - IDLE: cpu_rst_n=0. On start=1, next state is LEN_LO, busy=1, words_loaded cleared.
  - LEN_LO and LEN_HI: rx_ready=1; each captures one length byte.
  - After LEN_HI is accepted:
    - N=0: go to RUN.
    - N > 2**ADDR_W: go to ERROR.
    - Otherwise: go to WORD with byte index 0 and word index 0.
  - WORD: rx_ready=1. Each accepted byte is shifted into the assembler. After the 4th byte, go to WRITE.
  - WRITE: lasts exactly one cycle.
    - imem_we=1, imem_addr=word index, imem_wdata=assembled word, rx_ready=0.
    - The write pulse occurs the cycle after the 4th byte is accepted.
    - Then word index and words_loaded increment. If the new word index equals N, go to RUN; otherwise return to WORD.
  - RUN: cpu_rst_n=1, done=1, busy=0.
  - ERROR: err=1, busy=0, cpu_rst_n=0, rx_ready=0.
  - From RUN or ERROR, start=1 moves to LEN_LO.
    - The next cycle has cpu_rst_n=0, done=0, err=0, busy=1.
- start is ignored in LEN_LO, LEN_HI, WORD and WRITE.
- Timeout: in LEN_LO, LEN_HI and WORD, a counter increments on every cycle without an accepted byte and clears on each accepted byte. When the counter reaches TIMEOUT-1, go to ERROR.
- Word address wrap cannot occur: N is bounded by the ERROR check, so N = 2**ADDR_W writes addresses 0 through 2**ADDR_W-1 exactly once.

Decomposition:
- Package imem_loader_pkg holds:
  - state_t enum
  - LEN_BYTES = 2
  - BYTES_PER_WORD = 4
- Sub-module word_assembler: byte shift register plus 2-bit byte counter, with signals push, clear, word_valid and word.
- The top level holds the FSM, timeout counter, address counter and output registers.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles, then release -> all outputs 0 and rx_ready=0 until start.
- Two-word load: start, then bytes 02 00 13 05 50 00 93 05 10 00 ->
  - imem_we pulses at addr 0 with data 0x00500513, and at addr 1 with data 0x00100593;
  - then done=1, cpu_rst_n=1, words_loaded=2.
- Gappy source: same stream with rx_valid low for 3 cycles between bytes -> identical writes; rx_ready=0 on each WRITE cycle and no byte is lost.
- N=0: start, then bytes 00 00 -> no imem_we; RUN and cpu_rst_n=1 the cycle after the 2nd byte.
- Oversize: length bytes 01 10 (N=0x1001) -> err=1, no writes, cpu_rst_n=0; a subsequent start followed by bytes 01 00 and 4 word bytes -> recovers with done=1.
- Timeout and abort: stall for TIMEOUT cycles after 2 word bytes -> err=1. Separately, assert rst_n=0 mid-WORD -> IDLE with all outputs at reset values.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Byte-stream framing and FSM state encoding live here.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        WORD,
        WRITE,
        RUN,
        ERROR
    } state_t;

    localparam int LEN_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

    // States in which the loader is waiting for a byte from the stream.
    function automatic logic is_rx_state(input state_t s);
        return (s == LEN_LO) || (s == LEN_HI) || (s == WORD);
    endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Little-endian byte-to-word packer: the first byte pushed lands in bits 7:0.
// word_valid flags the push that completes a word, so the caller can react in the same cycle.
module word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic        clear,
    input  logic [7:0]  data,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0] cnt_q;

    // NOTE: synchronous reset inside the clocked block, and only non-blocking
    // assignments for state so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            word  <= '0;
        end else if (clear) begin
            cnt_q <= '0;
            word  <= '0;
        end else if (push) begin
            word  <= {data, word[31:8]};
            cnt_q <= cnt_q + 2'd1;
        end
    end

    assign word_valid = push && (cnt_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte stream into instruction memory as 32-bit words,
// holding the CPU in reset until the whole program has been written.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W  = 12,
    parameter int TIMEOUT = 50000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst_n,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int LEN_W = LEN_BYTES * 8;
    localparam int CMP_W = (ADDR_W + 1 > LEN_W) ? ADDR_W + 1 : LEN_W;
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    localparam logic [CMP_W-1:0] MAX_WORDS = CMP_W'(2 ** ADDR_W);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);

    state_t            state_q, state_n;
    logic [7:0]        len_lo_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  len_full;
    logic [ADDR_W:0]   words_q;
    logic [ADDR_W:0]   words_inc;
    logic [TMO_W-1:0]  tmo_q, tmo_n;

    logic accept;
    logic tmo_hit;
    logic load_start;
    logic asm_clear;
    logic asm_word_valid;
    logic [31:0] asm_word;

    assign accept     = rx_valid && rx_ready;
    assign len_full   = {rx_data, len_lo_q};
    assign words_inc  = words_q + 1'b1;
    assign tmo_hit    = (tmo_q == TMO_LAST);
    assign load_start = start && (state_q == IDLE || state_q == RUN || state_q == ERROR);
    assign asm_clear  = load_start || (state_q == LEN_HI && accept);

    word_assembler u_asm (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (accept && state_q == WORD),
        .clear      (asm_clear),
        .data       (rx_data),
        .word_valid (asm_word_valid),
        .word       (asm_word)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // NOTE: next-state and timer values get defaults before the case so no
    // path through the block leaves them unassigned (no latches).
    always_comb begin
        state_n = state_q;
        tmo_n   = '0;
        if (is_rx_state(state_q) && !accept) begin
            tmo_n = tmo_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start) state_n = LEN_LO;
            end
            LEN_LO: begin
                if (accept)       state_n = LEN_HI;
                else if (tmo_hit) state_n = ERROR;
            end
            LEN_HI: begin
                if (accept) begin
                    if (len_full == '0)                      state_n = RUN;
                    else if (CMP_W'(len_full) > MAX_WORDS)   state_n = ERROR;
                    else                                     state_n = WORD;
                end else if (tmo_hit) begin
                    state_n = ERROR;
                end
            end
            WORD: begin
                if (accept) begin
                    if (asm_word_valid) state_n = WRITE;
                end else if (tmo_hit) begin
                    state_n = ERROR;
                end
            end
            WRITE: begin
                if (CMP_W'(words_inc) == CMP_W'(len_q)) state_n = RUN;
                else                                     state_n = WORD;
            end
            RUN, ERROR: begin
                if (start) state_n = LEN_LO;
            end
            default: state_n = IDLE;
        endcase
    end

    // Length capture, word index / count and inter-byte timer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            len_lo_q <= '0;
            len_q    <= '0;
            words_q  <= '0;
            tmo_q    <= '0;
        end else begin
            tmo_q <= tmo_n;
            if (state_q == LEN_LO && accept) len_lo_q <= rx_data;
            if (state_q == LEN_HI && accept) len_q    <= len_full;
            if (load_start)                  words_q  <= '0;
            else if (state_q == WRITE)       words_q  <= words_inc;
        end
    end

    // Outputs are decoded from the next state so each one is a plain flop
    // that lines up with the state it describes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_ready  <= 1'b0;
            imem_we   <= 1'b0;
            imem_addr <= '0;
            cpu_rst_n <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            rx_ready  <= is_rx_state(state_n);
            imem_we   <= (state_n == WRITE);
            cpu_rst_n <= (state_n == RUN);
            busy      <= is_rx_state(state_n) || (state_n == WRITE);
            done      <= (state_n == RUN);
            err       <= (state_n == ERROR);
            if (state_n == WRITE) imem_addr <= words_q[ADDR_W-1:0];
        end
    end

    assign imem_wdata   = asm_word;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: framing, handshake gaps, length limits,
// timeout and mid-load reset, with hand-computed expectations.
module tb_imem_loader;

    localparam int ADDR_W     = 12;
    localparam int TB_TIMEOUT = 64;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_rst_n;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   words_loaded;

    int tests = 0;
    int fails = 0;
    int ready_in_write = 0;
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];

    imem_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TB_TIMEOUT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_rst_n    (cpu_rst_n),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    // Write-port monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (imem_we) begin
            wr_addr.push_back(32'(imem_addr));
            wr_data.push_back(imem_wdata);
            if (rx_ready) ready_in_write++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        idle(1);
        start = 1'b0;
    endtask

    // Offers one byte and returns #1 after the edge on which it was accepted.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        while (!rx_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready) check("rx_ready_wait", 32'(rx_ready), 32'd1);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic wait_end(input string tag, input logic want_done);
        int n;
        n = 0;
        while (!done && !err && n < 500) begin
            idle(1);
            n++;
        end
        check({tag, "_done"}, 32'(done), 32'(want_done));
        check({tag, "_err"},  32'(err),  32'(!want_done));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rx_ready"},  32'(rx_ready),     32'd0);
        check({tag, "_imem_we"},   32'(imem_we),      32'd0);
        check({tag, "_imem_addr"}, 32'(imem_addr),    32'd0);
        check({tag, "_wdata"},     imem_wdata,        32'd0);
        check({tag, "_cpu_rst_n"}, 32'(cpu_rst_n),    32'd0);
        check({tag, "_busy"},      32'(busy),         32'd0);
        check({tag, "_done"},      32'(done),         32'd0);
        check({tag, "_err"},       32'(err),          32'd0);
        check({tag, "_words"},     32'(words_loaded), 32'd0);
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        ready_in_write = 0;
    endtask

    logic [7:0] prog [10] = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};

    task automatic check_two_words(input string tag);
        check({tag, "_nwr"}, 32'(wr_addr.size()), 32'd2);
        if (wr_addr.size() == 2) begin
            check({tag, "_a0"}, wr_addr[0], 32'd0);
            check({tag, "_d0"}, wr_data[0], 32'h0050_0513);
            check({tag, "_a1"}, wr_addr[1], 32'd1);
            check({tag, "_d1"}, wr_data[1], 32'h0010_0593);
        end
        check({tag, "_cpu_rst_n"}, 32'(cpu_rst_n),    32'd1);
        check({tag, "_busy"},      32'(busy),         32'd0);
        check({tag, "_words"},     32'(words_loaded), 32'd2);
        check({tag, "_ready_wr"},  32'(ready_in_write), 32'd0);
    endtask

    initial begin
        int n;
        rst_n    = 1'b0;
        start    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;

        // Reset
        idle(2);
        rst_n = 1'b1;
        idle(1);
        check_reset_outputs("rst");
        rx_valid = 1'b1;
        idle(3);
        rx_valid = 1'b0;
        check("rst_idle_ready", 32'(rx_ready), 32'd0);

        // Back-to-back two-word load; write pulse the cycle after each 4th byte
        clear_log();
        pulse_start();
        check("tw_busy", 32'(busy), 32'd1);
        check("tw_ready", 32'(rx_ready), 32'd1);
        for (int i = 0; i < 10; i++) begin
            send_byte(prog[i]);
            if (i == 5 || i == 9) begin
                check($sformatf("tw_we_%0d", i), 32'(imem_we), 32'd1);
                check($sformatf("tw_rdy_%0d", i), 32'(rx_ready), 32'd0);
            end
        end
        wait_end("tw", 1'b1);
        check_two_words("tw");

        // Same stream with 3-cycle gaps; restart from RUN
        clear_log();
        pulse_start();
        check("gap_restart_cpu", 32'(cpu_rst_n), 32'd0);
        check("gap_restart_done", 32'(done), 32'd0);
        check("gap_restart_busy", 32'(busy), 32'd1);
        check("gap_restart_words", 32'(words_loaded), 32'd0);
        for (int i = 0; i < 10; i++) begin
            send_byte(prog[i]);
            idle(3);
        end
        wait_end("gap", 1'b1);
        check_two_words("gap");

        // N = 0: RUN right after the second length byte
        clear_log();
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h00);
        check("n0_done", 32'(done), 32'd1);
        check("n0_cpu", 32'(cpu_rst_n), 32'd1);
        idle(2);
        check("n0_nwr", 32'(wr_addr.size()), 32'd0);
        check("n0_words", 32'(words_loaded), 32'd0);

        // Oversize length 0x1001, then recovery with a one-word load
        clear_log();
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h10);
        check("big_err", 32'(err), 32'd1);
        check("big_cpu", 32'(cpu_rst_n), 32'd0);
        check("big_busy", 32'(busy), 32'd0);
        check("big_ready", 32'(rx_ready), 32'd0);
        idle(2);
        check("big_nwr", 32'(wr_addr.size()), 32'd0);
        pulse_start();
        check("rec_err", 32'(err), 32'd0);
        check("rec_busy", 32'(busy), 32'd1);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        send_byte(8'hDD);
        wait_end("rec", 1'b1);
        check("rec_nwr", 32'(wr_addr.size()), 32'd1);
        if (wr_addr.size() == 1) begin
            check("rec_a0", wr_addr[0], 32'd0);
            check("rec_d0", wr_data[0], 32'hDDCC_BBAA);
        end
        check("rec_cpu", 32'(cpu_rst_n), 32'd1);
        check("rec_words", 32'(words_loaded), 32'd1);

        // Exactly 2**ADDR_W words is a legal length
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h10);
        check("max_err", 32'(err), 32'd0);
        check("max_busy", 32'(busy), 32'd1);
        check("max_ready", 32'(rx_ready), 32'd1);
        wait_end("max_tmo", 1'b0);

        // Stall after two word bytes: err exactly TIMEOUT cycles later
        clear_log();
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h11);
        send_byte(8'h22);
        n = 0;
        while (!err && n < TB_TIMEOUT + 10) begin
            idle(1);
            n++;
        end
        check("tmo_cycles", 32'(n), 32'(TB_TIMEOUT));
        check("tmo_err", 32'(err), 32'd1);
        check("tmo_cpu", 32'(cpu_rst_n), 32'd0);
        check("tmo_nwr", 32'(wr_addr.size()), 32'd0);

        // Reset in the middle of a word
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h33);
        check("abort_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        idle(1);
        check_reset_outputs("abort");
        rst_n = 1'b1;
        idle(3);
        check_reset_outputs("abort_idle");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
